// File: rtl/instance_connection_pkg.sv
// Shared types for the instance-connection pipeline and its register slices.
package instance_connection_pkg;

    localparam int unsigned DEFAULT_WIDTH = 2;

    typedef enum logic {
        STAGE_EMPTY,
        STAGE_FULL
    } stage_state_t;

    typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage

// File: rtl/instance_connection_stage.sv
// One-entry valid/ready register slice: registered valid/data, combinational ready.
module instance_connection_stage
    import instance_connection_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             in_accept;

    // A full slice can still take a beat when downstream drains it in the same cycle.
    assign in_ready  = (state_q == STAGE_EMPTY) | out_ready;
    assign in_accept = in_valid & in_ready;
    assign out_valid = (state_q == STAGE_FULL);
    assign out_data  = data_q;

    // State and payload registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STAGE_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Next-state: fill on accept, drain on output accept, replace on simultaneous accept.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            STAGE_EMPTY: begin
                if (in_accept) begin
                    state_d = STAGE_FULL;
                    data_d  = in_data;
                end
            end
            STAGE_FULL: begin
                if (in_accept) begin
                    data_d = in_data;
                end else if (out_ready) begin
                    state_d = STAGE_EMPTY;
                end
            end
            default: state_d = STAGE_EMPTY;
        endcase
    end

endmodule

// File: rtl/instance_connection_pipeline.sv
// Two-stage register pipeline with packet beat tagging and a saturating stall counter.
module instance_connection_pipeline
    import instance_connection_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned PKT_LEN = 4,
    parameter int unsigned STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_last,
    output logic [3:0]         beat_idx,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam logic [3:0] LAST_IDX = 4'(PKT_LEN - 1);

    logic             s0_valid;
    logic             s0_ready;
    logic [WIDTH-1:0] s0_data;

    logic               out_accept;
    logic               stall_event;
    logic [3:0]         beat_q, beat_d;
    logic [STALL_W-1:0] stall_q, stall_d;

    instance_connection_stage #(.WIDTH(WIDTH)) u_stage0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (s0_valid),
        .out_ready (s0_ready),
        .out_data  (s0_data)
    );

    instance_connection_stage #(.WIDTH(WIDTH)) u_stage1 (
        clk, rst, s0_valid, s0_ready, s0_data, out_valid, out_ready, out_data
    );

    assign out_accept  = out_valid & out_ready;
    assign stall_event = out_valid & ~out_ready;

    assign beat_idx  = beat_q;
    assign stall_cnt = stall_q;
    assign out_last  = out_valid & (beat_q == LAST_IDX);

    // Beat index and stall counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q  <= '0;
            stall_q <= '0;
        end else begin
            beat_q  <= beat_d;
            stall_q <= stall_d;
        end
    end

    // Advance beat index per output accept; stall counter sticks at all-ones.
    always_comb begin
        beat_d  = beat_q;
        stall_d = stall_q;
        if (out_accept) begin
            beat_d = (beat_q == LAST_IDX) ? '0 : beat_q + 4'd1;
        end
        if (stall_event && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_instance_connection_pipeline.sv
// Directed bench: table-driven streaming plus hand-written stall, toggle and reset sequences.
module tb_instance_connection_pipeline;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [1:0] in_data = '0;

    logic       in_ready, out_valid, out_last;
    logic [1:0] out_data;
    logic [3:0] beat_idx;
    logic [7:0] stall_cnt;

    logic       s_in_ready, s_out_valid, s_out_last;
    logic [1:0] s_out_data;
    logic [3:0] s_beat_idx;
    logic [2:0] s_stall_cnt;

    logic       p_in_ready, p_out_valid, p_out_last;
    logic [1:0] p_out_data;
    logic [3:0] p_beat_idx;
    logic [7:0] p_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instance_connection_pipeline #(.WIDTH(2), .PKT_LEN(4), .STALL_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .beat_idx(beat_idx), .stall_cnt(stall_cnt)
    );

    instance_connection_pipeline #(.WIDTH(2), .PKT_LEN(4), .STALL_W(3)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_last(s_out_last), .beat_idx(s_beat_idx), .stall_cnt(s_stall_cnt)
    );

    instance_connection_pipeline #(.WIDTH(2), .PKT_LEN(2), .STALL_W(8)) dut_p2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(p_in_ready), .in_data(in_data),
        .out_valid(p_out_valid), .out_ready(out_ready), .out_data(p_out_data),
        .out_last(p_out_last), .beat_idx(p_beat_idx), .stall_cnt(p_stall_cnt)
    );

    typedef struct {
        logic       iv;
        logic [1:0] d;
        logic       ordy;
        logic       exp_ov;
        logic [1:0] exp_od;
        logic [3:0] exp_beat;
        logic       exp_last;
        logic [3:0] exp_beat2;
        logic       exp_last2;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_q[$];
        logic [1:0] nxt;
        logic [1:0] popped;
        logic [3:0] eb;
        logic [3:0] eb2;
        int         outs;

        // iv d or | ov od beat last | beat2 last2   (main PKT_LEN=4, second PKT_LEN=2)
        tbl[0]  = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl[1]  = '{1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'd3, 1'b1, 1'b1, 2'd1, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl[3]  = '{1'b1, 2'd0, 1'b1, 1'b1, 2'd2, 4'd1, 1'b0, 4'd1, 1'b1};
        tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd3, 4'd2, 1'b0, 4'd0, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd0, 4'd3, 1'b1, 4'd1, 1'b1};
        tbl[6]  = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl[8]  = '{1'b1, 2'd2, 1'b1, 1'b0, 2'd0, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl[9]  = '{1'b1, 2'd3, 1'b1, 1'b1, 2'd1, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl[10] = '{1'b1, 2'd0, 1'b1, 1'b1, 2'd2, 4'd1, 1'b0, 4'd1, 1'b1};
        tbl[11] = '{1'b1, 2'd1, 1'b1, 1'b1, 2'd3, 4'd2, 1'b0, 4'd0, 1'b0};
        tbl[12] = '{1'b1, 2'd2, 1'b1, 1'b1, 2'd0, 4'd3, 1'b1, 4'd1, 1'b1};
        tbl[13] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd1, 4'd0, 1'b0, 4'd0, 1'b0};
        tbl[14] = '{1'b0, 2'd0, 1'b1, 1'b1, 2'd2, 4'd1, 1'b0, 4'd1, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 1'b1, 1'b0, 2'd0, 4'd2, 1'b0, 4'd0, 1'b0};

        // Reset state, including in_ready high while reset is held.
        rst = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_beat_idx", 32'(beat_idx), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst = 1'b0;

        // Streams 1,2,3,0 then six more beats, checking both packet lengths.
        for (int i = 0; i < 16; i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].d;
            out_ready = tbl[i].ordy;
            @(negedge clk);
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov)
                chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].exp_od));
            chk($sformatf("tbl%0d_beat_idx", i), 32'(beat_idx), 32'(tbl[i].exp_beat));
            chk($sformatf("tbl%0d_out_last", i), 32'(out_last), 32'(tbl[i].exp_last));
            chk($sformatf("tbl%0d_p2_beat_idx", i), 32'(p_beat_idx), 32'(tbl[i].exp_beat2));
            chk($sformatf("tbl%0d_p2_out_last", i), 32'(p_out_last), 32'(tbl[i].exp_last2));
            cyc();
        end

        // Fill with 2,3 then hold out_ready low for five cycles.
        in_valid = 1'b1; in_data = 2'd2; out_ready = 1'b0;
        @(negedge clk);
        chk("t2_rdy_first", 32'(in_ready), 32'd1);
        chk("t2_ov_first", 32'(out_valid), 32'd0);
        cyc();
        in_data = 2'd3;
        @(negedge clk);
        chk("t2_rdy_second", 32'(in_ready), 32'd1);
        cyc();
        in_data = 2'd0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_full_in_ready", 32'(in_ready), 32'd0);
            chk("t2_hold_out_valid", 32'(out_valid), 32'd1);
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("t2_stall_cnt", 32'(stall_cnt), 32'd5);
        chk("t2_sat_stall_cnt", 32'(s_stall_cnt), 32'd5);
        chk("t2_rel_data0", 32'(out_data), 32'd2);
        chk("t2_rel_beat0", 32'(beat_idx), 32'd2);
        chk("t2_rel_last0", 32'(out_last), 32'd0);
        cyc();
        @(negedge clk);
        chk("t2_rel_valid1", 32'(out_valid), 32'd1);
        chk("t2_rel_data1", 32'(out_data), 32'd3);
        chk("t2_rel_last1", 32'(out_last), 32'd1);
        cyc();
        out_ready = 1'b0;
        @(negedge clk);
        chk("t2_drained", 32'(out_valid), 32'd0);
        chk("t2_beat_wrapped", 32'(beat_idx), 32'd0);
        cyc();
        @(negedge clk);
        chk("t2_empty_no_stall", 32'(stall_cnt), 32'd5);
        cyc();

        // Toggle out_ready with continuous incrementing input; scoreboard order.
        nxt = 2'd0; eb = beat_idx === 4'd0 ? 4'd0 : 4'd0; eb2 = 4'd0; outs = 0;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_data   = nxt;
            out_ready = (i % 2 == 0);
            @(negedge clk);
            if (out_valid && out_ready) begin
                chk("t4_has_expected", 32'(exp_q.size() > 0), 32'd1);
                popped = (exp_q.size() > 0) ? exp_q.pop_front() : 2'bxx;
                chk("t4_out_data", 32'(out_data), 32'(popped));
                chk("t4_beat_idx", 32'(beat_idx), 32'(eb));
                chk("t4_out_last", 32'(out_last), 32'(eb == 4'd3));
                chk("t4_p2_beat_idx", 32'(p_beat_idx), 32'(eb2));
                eb   = (eb == 4'd3) ? 4'd0 : eb + 4'd1;
                eb2  = (eb2 == 4'd1) ? 4'd0 : eb2 + 4'd1;
                outs++;
            end
            if (in_ready) begin
                exp_q.push_back(nxt);
                nxt = nxt + 2'd1;
            end
            cyc();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 6 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                popped = exp_q.pop_front();
                chk("t4_drain_data", 32'(out_data), 32'(popped));
                chk("t4_drain_beat", 32'(beat_idx), 32'(eb));
                eb = (eb == 4'd3) ? 4'd0 : eb + 4'd1;
                outs++;
            end
            cyc();
        end
        @(negedge clk);
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("t4_out_valid_end", 32'(out_valid), 32'd0);
        chk("t4_wrapped_once", 32'(outs >= 5), 32'd1);
        cyc();

        // Clean start for saturation; one beat drains so beat_idx is nonzero.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 2'd1; out_ready = 1'b1;
        @(negedge clk);
        chk("t3_start_stall", 32'(s_stall_cnt), 32'd0);
        cyc();
        in_data = 2'd2;
        cyc();
        in_data = 2'd3;
        @(negedge clk);
        chk("t3_first_out", 32'(out_data), 32'd1);
        cyc();
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) chk("t3_full_in_ready", 32'(in_ready), 32'd0);
            cyc();
        end
        @(negedge clk);
        chk("t3_sat_stall_cnt", 32'(s_stall_cnt), 32'd7);
        chk("t3_main_stall_cnt", 32'(stall_cnt), 32'd10);
        chk("t3_hold_data", 32'(out_data), 32'd2);
        chk("t3_hold_beat", 32'(beat_idx), 32'd1);

        // Asynchronous reset mid-cycle with both stages full.
        #1 rst = 1'b1;
        #1;
        chk("t5_async_out_valid", 32'(out_valid), 32'd0);
        chk("t5_async_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("t5_async_sat_stall", 32'(s_stall_cnt), 32'd0);
        chk("t5_async_beat_idx", 32'(beat_idx), 32'd0);
        chk("t5_async_in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst = 1'b0;
        in_valid = 1'b1; in_data = 2'd3; out_ready = 1'b1;
        @(negedge clk);
        chk("t5_post_ov0", 32'(out_valid), 32'd0);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("t5_post_ov1", 32'(out_valid), 32'd0);
        cyc();
        @(negedge clk);
        chk("t5_post_valid", 32'(out_valid), 32'd1);
        chk("t5_post_data", 32'(out_data), 32'd3);
        chk("t5_post_beat", 32'(beat_idx), 32'd0);
        chk("t5_post_last", 32'(out_last), 32'd0);
        chk("t5_post_p2_last", 32'(p_out_last), 32'd0);
        cyc();
        @(negedge clk);
        chk("t5_post_drained", 32'(out_valid), 32'd0);
        chk("t5_post_beat_next", 32'(beat_idx), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
